// File: rtl/uart_baud_gen_pkg.sv
// -----------------------------------------------------------------------------
// uart_baud_gen_pkg
// Shared UART constants and CSR field layouts used by the baud-rate generator
// and its parent.
//   UART_DIV_W / UART_FRAC_W : widths of the integer / fractional divisor fields
//   UART_OS_RATE             : oversample ticks per bit (even, >= 4)
//   UART_MIN_DIV             : smallest legal integer divisor
// -----------------------------------------------------------------------------
package uart_baud_gen_pkg;

  localparam int UART_DIV_W   = 16;
  localparam int UART_FRAC_W  = 4;
  localparam int UART_OS_RATE = 16;
  localparam int UART_MIN_DIV = 2;

  // Baud divisor register: integer part plus fraction in 1/2^FRAC_W clocks.
  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } uart_baud_rate_csr_t;

  // Control register 0: only the baud enable is consumed here.
  typedef struct packed {
    logic [6:0] rsvd;
    logic       enable;
  } uart_control_0_csr_t;

endpackage : uart_baud_gen_pkg

// File: rtl/uart_baud_gen_frac_div.sv
// -----------------------------------------------------------------------------
// uart_frac_div
// Fractional clock divider producing the oversample strobe.
// A down-counter runs for div_int clocks; every reload adds div_frac to an
// accumulator and stretches the next period by one clock on carry-out, so the
// average period is div_int + div_frac/2^FRAC_W clocks.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : force the post-reload start state (idle, start, sync)
//   run_i         : count enable; ignored while load_i is high
//   div_int_i     : integer divisor (sampled only at load/reload)
//   div_frac_i    : fractional divisor (sampled only at reload)
//   reload_o      : combinational, high in the cycle the counter expires
//   os_tick_o     : registered oversample strobe, one clock wide
// -----------------------------------------------------------------------------
module uart_frac_div
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              run_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              reload_o,
  output logic              os_tick_o
);

  localparam logic [DIV_W:0] ONE = 1;

  logic [DIV_W:0]  div_cnt_q, div_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [DIV_W:0]  period_q, period_d;
  logic            os_tick_q, os_tick_d;

  logic [FRAC_W:0] frac_sum;
  logic [DIV_W:0]  start_val;
  logic [DIV_W:0]  reload_val;

  // Top bit of frac_sum is the carry that lengthens the next period.
  assign frac_sum   = {1'b0, frac_acc_q} + {1'b0, div_frac_i};
  assign start_val  = {1'b0, div_int_i} - ONE;
  assign reload_val = start_val + {{DIV_W{1'b0}}, frac_sum[FRAC_W]};
  assign reload_o   = run_i & ~load_i & (div_cnt_q == '0);

  always_comb begin
    div_cnt_d  = div_cnt_q;
    frac_acc_d = frac_acc_q;
    period_d   = period_q;
    os_tick_d  = 1'b0;
    if (load_i) begin
      div_cnt_d  = start_val;
      frac_acc_d = '0;
      period_d   = start_val;
    end else if (reload_o) begin
      // The divisor is only looked at here, so a CSR write never
      // shortens or stretches the period already in flight.
      div_cnt_d  = reload_val;
      frac_acc_d = frac_sum[FRAC_W-1:0];
      period_d   = reload_val;
      os_tick_d  = 1'b1;
    end else if (run_i) begin
      div_cnt_d  = div_cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= start_val;
      frac_acc_q <= '0;
      period_q   <= start_val;
      os_tick_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      frac_acc_q <= frac_acc_d;
      period_q   <= period_d;
      os_tick_q  <= os_tick_d;
    end
  end

  // period_q is the length (minus one) of the current period, kept as a
  // debug probe point; it has no downstream consumer in logic.
  logic unused_period;
  assign unused_period = ^period_q;

  assign os_tick_o = os_tick_q;

endmodule : uart_frac_div

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Baud-rate tick generator for the UART TX/RX engines.
// Produces one-clock oversample, mid-bit and bit-boundary strobes from a
// fractional divisor. OS_RATE must be even and at least 4.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   div_int    : integer divisor (legal when >= 2)
//   div_frac   : fractional divisor in 1/2^FRAC_W clocks
//   enable     : baud enable
//   sync       : one-cycle phase restart from the RX start-bit detector
//   os_tick    : oversample strobe
//   mid_tick   : strobe on the oversample tick in the middle of a bit
//   bit_tick   : strobe on the last oversample tick of a bit
//   cfg_err    : registered "divisor below 2" flag (not sticky)
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W   = UART_DIV_W,
  parameter int FRAC_W  = UART_FRAC_W,
  parameter int OS_RATE = UART_OS_RATE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              enable,
  input  logic              sync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_err
);

  localparam int               OS_W    = $clog2(OS_RATE);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE  = 1;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(UART_MIN_DIV);

  logic            div_legal;
  logic            active;
  logic            load;
  logic            reload;
  logic            run_q, run_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic            mid_tick_q, mid_tick_d;
  logic            bit_tick_q, bit_tick_d;
  logic            cfg_err_q, cfg_err_d;

  assign div_legal = (div_int >= MIN_DIV);
  assign active    = enable & div_legal;

  // Restart the divider whenever we are idle, on the first enabled edge
  // (run_q still low) and on sync. rst / enable low / illegal divisor are
  // all folded in here, so they naturally win over sync, and sync wins over
  // a reload due in the same cycle.
  assign load = rst | ~active | ~run_q | sync;

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .run_i      (active),
    .div_int_i  (div_int),
    .div_frac_i (div_frac),
    .reload_o   (reload),
    .os_tick_o  (os_tick)
  );

  always_comb begin
    os_cnt_d   = os_cnt_q;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    run_d      = active;
    cfg_err_d  = ~div_legal;
    if (load) begin
      os_cnt_d = '0;
    end else if (reload) begin
      // Decode against the count before it advances so mid/bit line up
      // with the os_tick registered in the same cycle.
      mid_tick_d = (os_cnt_q == OS_MID);
      bit_tick_d = (os_cnt_q == OS_LAST);
      os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      os_cnt_q   <= '0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      os_cnt_q   <= os_cnt_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign cfg_err  = cfg_err_q;

endmodule : uart_baud_gen

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

  localparam int OS     = 16;
  localparam int FRAC_N = 16;   // 2^FRAC_W

  logic        clk;
  logic        rst;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        enable;
  logic        sync;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic        cfg_err;

  uart_baud_gen dut (
    .clk      (clk),
    .rst      (rst),
    .div_int  (div_int),
    .div_frac (div_frac),
    .enable   (enable),
    .sync     (sync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycle n is the clock period following rising edge n.
  int   cyc = 0;
  bit   m_active = 0;
  int   m_next_os = 0;
  int   m_bitpos = 0;
  int   m_acc = 0;
  logic exp_os = 0, exp_mid = 0, exp_bit = 0, exp_cfg = 0;

  int os_q[$];
  int mid_q[$];
  int bit_q[$];

  // Event-time model: remembers when the next oversample tick is due and
  // how far into the bit we are, rather than modelling any counters.
  function automatic void model_step();
    exp_os  = 0;
    exp_mid = 0;
    exp_bit = 0;
    if (rst) begin
      exp_cfg  = 0;
      m_active = 0;
    end else begin
      exp_cfg = (int'(div_int) < 2);
      if (!enable || int'(div_int) < 2) begin
        m_active = 0;
      end else if (!m_active || sync) begin
        m_active  = 1;
        m_next_os = cyc + int'(div_int);
        m_bitpos  = 0;
        m_acc     = 0;
      end else if (cyc == m_next_os) begin
        exp_os    = 1;
        exp_mid   = (m_bitpos == OS / 2 - 1);
        exp_bit   = (m_bitpos == OS - 1);
        m_bitpos  = (m_bitpos + 1) % OS;
        m_acc     = m_acc + int'(div_frac);
        m_next_os = cyc + int'(div_int) + m_acc / FRAC_N;
        m_acc     = m_acc % FRAC_N;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    checks++;
    if ({os_tick, mid_tick, bit_tick, cfg_err} !== {exp_os, exp_mid, exp_bit, exp_cfg}) begin
      errors++;
      $display("FAIL outputs cycle %0d: os/mid/bit/cfg got %b%b%b%b expected %b%b%b%b",
               cyc, os_tick, mid_tick, bit_tick, cfg_err, exp_os, exp_mid, exp_bit, exp_cfg);
    end
    if (os_tick === 1'b1)  os_q.push_back(cyc);
    if (mid_tick === 1'b1) mid_q.push_back(cyc);
    if (bit_tick === 1'b1) bit_q.push_back(cyc);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int first_after(input int q[$], input int x);
    foreach (q[k]) if (q[k] > x) return q[k];
    return -1;
  endfunction

  function automatic void clear_q();
    os_q.delete();
    mid_q.delete();
    bit_q.delete();
  endfunction

  int e, f, s, s2, r;

  initial begin
    rst = 1; enable = 0; sync = 0; div_int = 16'd4; div_frac = 4'd0;
    repeat (3) tick();
    chk("reset_os", int'(os_tick), 0);
    chk("reset_bit", int'(bit_tick), 0);
    chk("reset_cfg", int'(cfg_err), 0);
    rst = 0;
    tick();
    $display("test reset: cycle=%0d", cyc);

    // Integer divisor 4
    clear_q(); enable = 1; e = cyc + 1;
    repeat (140) tick();
    chk("int_first_os", qget(os_q, 0), e + 4);
    chk("int_os_period", qget(os_q, 1) - qget(os_q, 0), 4);
    chk("int_first_mid", qget(mid_q, 0), e + 32);
    chk("int_first_bit", qget(bit_q, 0), e + 64);
    chk("int_second_bit", qget(bit_q, 1), e + 128);
    $display("test integer: os_ticks=%0d bit_ticks=%0d", os_q.size(), bit_q.size());

    // Enable low stops ticks at once
    enable = 0; clear_q();
    repeat (20) tick();
    chk("disable_no_os", os_q.size(), 0);
    $display("test disable: cycle=%0d", cyc);

    // Fractional 4 + 8/16
    div_frac = 4'd8; clear_q(); enable = 1; e = cyc + 1;
    repeat (100) tick();
    chk("frac_first_os", qget(os_q, 0), e + 4);
    chk("frac_gap_a", qget(os_q, 1) - qget(os_q, 0), 4);
    chk("frac_gap_b", qget(os_q, 2) - qget(os_q, 1), 5);
    chk("frac_span16", qget(os_q, 16) - qget(os_q, 0), 72);
    $display("test fractional: os_ticks=%0d", os_q.size());

    // Illegal divisor, then recover
    enable = 0; tick();
    div_frac = 4'd0; div_int = 16'd1; enable = 1; clear_q();
    tick();
    chk("illegal_cfg_err", int'(cfg_err), 1);
    repeat (200) tick();
    chk("illegal_no_os", os_q.size(), 0);
    chk("illegal_no_bit", bit_q.size(), 0);
    div_int = 16'd3; f = cyc + 1;
    tick();
    chk("legal_cfg_err", int'(cfg_err), 0);
    repeat (10) tick();
    chk("legal_first_os", first_after(os_q, f - 1), f + 3);
    $display("test illegal: cycle=%0d", cyc);

    // Sync mid-bit with divisor 5
    enable = 0; tick();
    div_int = 16'd5; enable = 1; clear_q(); e = cyc + 1;
    s = e + 47;                       // nine ticks done, os count is 9
    run_until(s - 1);
    sync = 1; tick(); sync = 0;
    run_until(s + 85);
    chk("sync_next_os", first_after(os_q, s), s + 5);
    chk("sync_next_mid", first_after(mid_q, s), s + 40);
    chk("sync_next_bit", first_after(bit_q, s), s + 80);
    s2 = s + 100;                     // a tick is due exactly here
    run_until(s2 - 1);
    sync = 1; tick(); sync = 0;
    run_until(s2 + 12);
    chk("sync_pre_os", first_after(os_q, s + 90), s + 95);
    chk("sync_suppress", first_after(os_q, s + 95), s2 + 5);
    $display("test sync: cycle=%0d", cyc);

    // Divisor change 6 -> 3 in the middle of a period
    enable = 0; tick();
    div_int = 16'd6; enable = 1; clear_q(); e = cyc + 1;
    run_until(e + 7);
    div_int = 16'd3;                  // sampled at e+8, counter mid-period
    run_until(e + 20);
    chk("chg_first_os", first_after(os_q, e), e + 6);
    chk("chg_old_period", first_after(os_q, e + 6), e + 12);
    chk("chg_new_period_a", first_after(os_q, e + 12), e + 15);
    chk("chg_new_period_b", first_after(os_q, e + 15), e + 18);
    $display("test divchange: cycle=%0d", cyc);

    // Reset while running at os count 7
    enable = 0; tick();
    div_int = 16'd4; enable = 1; clear_q(); e = cyc + 1;
    r = e + 30;
    run_until(r - 1);
    rst = 1; tick();
    chk("rst_os", int'(os_tick), 0);
    chk("rst_mid", int'(mid_tick), 0);
    rst = 0;
    run_until(r + 40);
    chk("rst_next_os", first_after(os_q, r), r + 5);
    chk("rst_next_mid", first_after(mid_q, r), r + 33);
    $display("test reset_mid: cycle=%0d", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_baud_gen

// File: doc/uart_baud_gen.md
# uart_baud_gen

Baud-rate tick generator for the UART. It consumes the baud-rate divisor and enable fields that the CSR block publishes on `UART_csr_if.uart_mp`. It produces single-cycle oversample, mid-bit and bit-boundary strobes, which the TX and RX engines use for serialization and sampling. A fractional divisor gives accurate baud rates from arbitrary system clocks. A sync input lets the RX engine realign bit phase on a start-bit edge.

## Interface
Parameters:
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W clock.
- `OS_RATE`, 16: oversample ticks per bit. Must be even and ≥ 4.

Ports:
- `clk`, input, 1: single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `div_int`, input, DIV_W: integer divisor, driven from `uart_baud_rate_csr`.
- `div_frac`, input, FRAC_W: fractional divisor, driven from `uart_baud_rate_csr`.
- `enable`, input, 1: baud enable, driven from `uart_control_0_csr`.
- `sync`, input, 1: one-cycle phase-restart pulse from the RX engine.
- `os_tick`, output, 1: oversample strobe.
- `mid_tick`, output, 1: mid-bit sample strobe.
- `bit_tick`, output, 1: bit-boundary strobe.
- `cfg_err`, output, 1: divisor illegal (below 2); routed to `uart_status_0_csr` by the parent.

## Operation
- State registers:
  - `div_cnt` (DIV_W+1 bits): down-counter for the oversample period.
  - `frac_acc` (FRAC_W bits): fractional accumulator.
  - `os_cnt` (log2 OS_RATE bits): oversample counter within a bit.
  - `period_q`: divisor snapshot taken at each reload.
- Configuration legality:
  - A divisor is illegal when `div_int < 2`.
  - When illegal, `cfg_err` = 1, the block is held in its idle state, and no ticks are produced.
  - `cfg_err` is a registered copy of the comparison; it is not sticky.
- Idle state (`rst`, `enable` = 0, or illegal divisor):
  - `div_cnt` = `div_int` − 1.
  - `frac_acc` = 0 and `os_cnt` = 0.
  - All tick outputs = 0.
- Running:
  - `div_cnt` decrements each cycle.
  - When `div_cnt` reaches 0, `os_tick` pulses for one cycle and the divisor is reloaded.
  - Reload adds `div_frac` to `frac_acc`.
  - Reload value is `div_int` − 1 + carry, where carry is the overflow of that fractional addition.
  - Average oversample period is therefore `div_int` + `div_frac`/2^FRAC_W clocks.
  - `os_cnt` increments on each `os_tick` and wraps from OS_RATE−1 to 0.
  - `mid_tick` coincides with the `os_tick` on which `os_cnt` = OS_RATE/2−1.
  - `bit_tick` coincides with the `os_tick` on which `os_cnt` = OS_RATE−1.
- Divisor change while running:
  - `div_int` and `div_frac` are sampled only at reload.
  - The in-flight period completes at the old value; no short or long glitch period occurs.
  - A change to an illegal value takes effect immediately: the block goes idle and `cfg_err` rises.
- `sync`:
  - Returns all counters to their post-reload start: `div_cnt` = `div_int` − 1, `frac_acc` = 0, `os_cnt` = 0.
  - Any tick due in the same cycle is suppressed.
  - `sync` has priority over the reload, but `rst` and `enable` = 0 have priority over `sync`.
- Reset mid-operation: all state returns to idle on the next edge. Ticks are 0 in the cycle after `rst` is sampled.

## Timing
- All outputs are flop outputs. All reset to 0.
- Ticks are exactly one cycle wide and never assert back-to-back, since the minimum period is 2.
- Latency, with `enable` first sampled high at edge E and legal `div_int` = N, `div_frac` = 0:
  - first `os_tick` is in cycle E+N;
  - subsequent `os_tick`s every N cycles;
  - first `bit_tick` is in cycle E+N·OS_RATE.
- `sync` sampled at edge S: next `os_tick` in cycle S+N, next `mid_tick` in cycle S+N·OS_RATE/2, next `bit_tick` in cycle S+N·OS_RATE.
- `cfg_err` follows the divisor with 1 cycle latency.
- `enable` deassertion: ticks stop in the next cycle.

## Structure
- `OS_RATE` and the minimum divisor constant (2) go in the shared UART package, alongside the CSR typedefs. The divisor field widths there must match `DIV_W` and `FRAC_W`.
- One natural sub-module: `uart_frac_div`. It holds `div_cnt`, `frac_acc` and `period_q`, and outputs `os_tick`.
- `uart_baud_gen` itself adds `os_cnt`, the mid/bit decode, `cfg_err` and the sync/enable priority logic.

## Test plan
- Integer rate: `div_int` = 4, `div_frac` = 0, `enable` = 1 → `os_tick` every 4 cycles, `mid_tick` at cycle 32, `bit_tick` every 64 cycles.
- Fractional rate: `div_int` = 4, `div_frac` = 8 → periods alternate 4, 5, 4, 5; 16 `os_tick`s span exactly 72 cycles.
- Illegal divisor: `div_int` = 1 → `cfg_err` = 1 one cycle later and no ticks for 200 cycles. Then `div_int` = 3 → `cfg_err` = 0, and the first `os_tick` arrives 3 cycles after the following edge.
- Sync mid-bit: `div_int` = 5 and `sync` pulsed at `os_cnt` = 9 → next `os_tick` 5 cycles later, `mid_tick` 40 cycles later, `bit_tick` 80 cycles later. A tick coincident with `sync` is suppressed.
- Divisor change: `div_int` changed 6→3 with `div_cnt` = 4 → current period finishes at 6 cycles, then 3-cycle periods follow.
- Reset/enable mid-operation: `rst` pulse at `os_cnt` = 7 → all outputs 0 the next cycle and the counters restart from 0. `enable` low → ticks stop within 1 cycle.
